mini_lab0: RTL and testbench



---
 rtl/mini_lab0.sv | 80 ++++++++
 tb/tb_mini_lab0.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mini_lab0.sv
// Lab-board switch-to-LED mirror: two-flop synchronizer, optional per-bit debounce.
// Define MINILAB0_DEBOUNCE_EN to build the debounce counters; otherwise LEDR follows s2 directly.
module mini_lab0 #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             KEY0,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] LEDR
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 3) begin : g_bad_debounce
    $error("mini_lab0: DEBOUNCE_CYCLES must be in 1..3");
  end

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk) begin
    if (KEY0) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= SW;
      s2 <= s1;
    end
  end

`ifdef MINILAB0_DEBOUNCE_EN

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0]  cnt      [WIDTH];
  logic [CntW-1:0]  cnt_next [WIDTH];
  logic [WIDTH-1:0] ledr_next;

  // A bit only moves once it has differed from LEDR for DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    ledr_next = LEDR;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != LEDR[i]) begin
        if (cnt[i] == CntMax) begin
          ledr_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (KEY0) begin
      LEDR <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      LEDR <= ledr_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`else

  always_ff @(posedge clk) begin
    if (KEY0) begin
      LEDR <= '0;
    end else begin
      LEDR <= s2;
    end
  end

`endif

endmodule

// File: tb/tb_mini_lab0.sv
// Scoreboard bench for mini_lab0: stimulus queues cycle-tagged LED expectations,
// a monitor compares LEDR against them mid-cycle.
module tb_mini_lab0;

`ifdef MINILAB0_DEBOUNCE_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 3;
`endif

  logic       clk = 1'b0;
  logic       KEY0;
  logic [9:0] SW;
  logic [9:0] LEDR;

  mini_lab0 #(
    .WIDTH          (10),
    .DEBOUNCE_CYCLES(2)
  ) dut (
    .clk (clk),
    .KEY0(KEY0),
    .SW  (SW),
    .LEDR(LEDR)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [9:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   total  = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectation for LEDR as seen after edge number (current cyc + off).
  task automatic push(input int off, input logic [9:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + off;
    e.exp  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: mid-cycle, retire every expectation tagged for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc <= cyc) begin
          total++;
          if (q[i].cyc < cyc) begin
            $display("FAIL %s: check for cycle %0d missed at cycle %0d", q[i].name, q[i].cyc, cyc);
          end else if (LEDR !== q[i].exp) begin
            $display("FAIL %s: cycle %0d LEDR=%h expected %h", q[i].name, cyc, LEDR, q[i].exp);
          end else begin
            passed++;
          end
          q.delete(i);
        end
      end
    end
  end

  logic [9:0] vecs [6];
  logic [9:0] prev;
  logic [9:0] r;

  initial begin
    vecs[0] = 10'h155; vecs[1] = 10'h3FF; vecs[2] = 10'h000;
    vecs[3] = 10'h2A5; vecs[4] = 10'h1C3; vecs[5] = 10'h3E0;

    // Reset held for edges 1 and 2 with all switches on.
    KEY0 = 1'b1;
    SW   = 10'h3FF;
    step(1);
    push(0, 10'h000, "rst_edge1");
    step(1);
    push(0, 10'h000, "rst_edge2");
    KEY0 = 1'b0;
    push(Lat - 1, 10'h000, "rst_release_early");
    push(Lat, 10'h3FF, "rst_release");
    step(Lat + 1);

    // Latency exactness.
    SW = 10'h000;
    step(Lat + 1);
    push(0, 10'h000, "lat_base");
    SW = 10'h2A5;
    push(Lat - 1, 10'h000, "lat_early");
    push(Lat, 10'h2A5, "lat_exact");
    step(Lat + 1);

    // Reset in the middle of a pending change.
    SW = 10'h155;
    step(Lat + 1);
    push(0, 10'h155, "mid_pre");
    SW   = 10'h0AA;
    KEY0 = 1'b1;
    push(1, 10'h000, "mid_rst");
    step(1);
    KEY0 = 1'b0;
    push(Lat - 1, 10'h000, "mid_release_early");
    push(Lat, 10'h0AA, "mid_release");
    step(Lat + 1);

    // Bits 9 and 0 flip together; the rest hold.
    SW = 10'h2AB;
    push(Lat - 1, 10'h0AA, "indep_early");
    push(Lat, 10'h2AB, "indep");
    step(Lat + 1);

    // One-edge pulse on bit 0.
    SW = 10'h000;
    step(Lat + 1);
    push(0, 10'h000, "glitch_base");
    SW = 10'h001;
`ifdef MINILAB0_DEBOUNCE_EN
    for (int k = 1; k <= 7; k++) push(k, 10'h000, "glitch_reject");
`else
    push(2, 10'h000, "pulse_before");
    push(3, 10'h001, "pulse_seen");
    push(4, 10'h000, "pulse_after");
`endif
    step(1);
    SW = 10'h000;
    step(Lat + 3);

    // Directed vectors, each held long enough to propagate.
    prev = 10'h000;
    for (int i = 0; i < 6; i++) begin
      SW = vecs[i];
      push(Lat - 1, prev, "vec_early");
      push(Lat, vecs[i], "vec");
      prev = vecs[i];
      step(Lat + 1);
    end

    // A handful of random mirrors.
    for (int i = 0; i < 20; i++) begin
      r  = 10'($urandom);
      SW = r;
      push(Lat + 1, r, "rand_mirror");
      step(Lat + 1);
    end

    for (int k = 0; k < 50 && q.size() > 0; k++) step(1);
    while (q.size() > 0) begin
      total++;
      $display("FAIL %s: expectation for cycle %0d never checked", q[0].name, q[0].cyc);
      void'(q.pop_front());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
